// File: rtl/seven_seg_pkg.sv
// Shared segment codes, BCD-to-segment decode and converter state encoding
// for the multiplexed seven-segment display path.
package seven_seg_pkg;

  localparam int unsigned SEG_W = 7;
  localparam int unsigned NIB_W = 4;

  // Active-low, bit order g f e d c b a
  localparam logic [SEG_W-1:0] SEG_0     = 7'b1000000;
  localparam logic [SEG_W-1:0] SEG_1     = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_2     = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_3     = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_4     = 7'b0011001;
  localparam logic [SEG_W-1:0] SEG_5     = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_6     = 7'b0000010;
  localparam logic [SEG_W-1:0] SEG_7     = 7'b1111000;
  localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_9     = 7'b0010000;
  localparam logic [SEG_W-1:0] SEG_DASH  = 7'b0111111;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    CONV_IDLE   = 2'd0,
    CONV_SHIFT  = 2'd1,
    CONV_COMMIT = 2'd2
  } conv_state_e;

  function automatic logic [SEG_W-1:0] bcd_to_seg(input logic [NIB_W-1:0] nib);
    logic [SEG_W-1:0] code;
    case (nib)
      4'd0:    code = SEG_0;
      4'd1:    code = SEG_1;
      4'd2:    code = SEG_2;
      4'd3:    code = SEG_3;
      4'd4:    code = SEG_4;
      4'd5:    code = SEG_5;
      4'd6:    code = SEG_6;
      4'd7:    code = SEG_7;
      4'd8:    code = SEG_8;
      4'd9:    code = SEG_9;
      default: code = SEG_BLANK;
    endcase
    return code;
  endfunction

  // 10^n, wide enough for the full digit range
  function automatic logic [63:0] pow10(input int unsigned n);
    logic [63:0] p;
    p = 64'd1;
    for (int unsigned i = 0; i < n; i++) begin
      p = p * 64'd10;
    end
    return p;
  endfunction

endpackage

// File: rtl/bcd_seq_converter.sv
// Sequential double-dabble binary-to-BCD converter with valid/ready input;
// publishes digits and overflow flag on commit.
module bcd_seq_converter
  import seven_seg_pkg::*;
#(
  parameter int unsigned DATA_W     = 14,
  parameter int unsigned NUM_DIGITS = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DATA_W-1:0]           in_data,
  output logic [NIB_W*NUM_DIGITS-1:0] digits,
  output logic                        ovf
);

  localparam int unsigned BCD_W     = NIB_W * NUM_DIGITS;
  localparam int unsigned CNT_W     = $clog2(DATA_W + 1);
  localparam logic [63:0] OVF_LIMIT = pow10(NUM_DIGITS);

  conv_state_e        r_state, w_state_nxt;
  logic [DATA_W-1:0]  r_bin, w_bin_nxt;
  logic [BCD_W-1:0]   r_bcd, w_bcd_nxt, w_bcd_adj;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic               r_pend_ovf, w_pend_ovf_nxt;
  logic [BCD_W-1:0]   r_digits, w_digits_nxt;
  logic               r_ovf, w_ovf_nxt;
  logic               r_in_ready;

  // Add-3 correction on every nibble that would exceed 9 after the shift
  always_comb begin
    w_bcd_adj = r_bcd;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (r_bcd[i*NIB_W +: NIB_W] >= 4'd5) begin
        w_bcd_adj[i*NIB_W +: NIB_W] = r_bcd[i*NIB_W +: NIB_W] + 4'd3;
      end
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_bin_nxt      = r_bin;
    w_bcd_nxt      = r_bcd;
    w_cnt_nxt      = r_cnt;
    w_pend_ovf_nxt = r_pend_ovf;
    w_digits_nxt   = r_digits;
    w_ovf_nxt      = r_ovf;
    case (r_state)
      CONV_IDLE: begin
        if (in_valid) begin
          w_bin_nxt      = in_data;
          w_bcd_nxt      = '0;
          w_cnt_nxt      = CNT_W'(DATA_W);
          w_pend_ovf_nxt = (64'(in_data) >= OVF_LIMIT);
          w_state_nxt    = CONV_SHIFT;
        end
      end
      CONV_SHIFT: begin
        w_bcd_nxt = {w_bcd_adj[BCD_W-2:0], r_bin[DATA_W-1]};
        w_bin_nxt = r_bin << 1;
        w_cnt_nxt = r_cnt - CNT_W'(1);
        if (r_cnt == CNT_W'(1)) begin
          w_state_nxt = CONV_COMMIT;
        end
      end
      CONV_COMMIT: begin
        w_digits_nxt = r_bcd;
        w_ovf_nxt    = r_pend_ovf;
        w_state_nxt  = CONV_IDLE;
      end
      default: begin
        w_state_nxt = CONV_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= CONV_IDLE;
      r_bin      <= '0;
      r_bcd      <= '0;
      r_cnt      <= '0;
      r_pend_ovf <= 1'b0;
      r_digits   <= '0;
      r_ovf      <= 1'b0;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_bin      <= w_bin_nxt;
      r_bcd      <= w_bcd_nxt;
      r_cnt      <= w_cnt_nxt;
      r_pend_ovf <= w_pend_ovf_nxt;
      r_digits   <= w_digits_nxt;
      r_ovf      <= w_ovf_nxt;
      r_in_ready <= (w_state_nxt == CONV_IDLE);
    end
  end

  assign in_ready = r_in_ready;
  assign digits   = r_digits;
  assign ovf      = r_ovf;

endmodule

// File: rtl/seven_segment_mux.sv
// Multi-digit seven-segment driver: binary in, BCD conversion, time-multiplexed
// active-low segment bus with leading-zero blanking and overflow dashes.
module seven_segment_mux
  import seven_seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned DATA_W      = 14,
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned BLANK_LZ    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_data,
  output logic [SEG_W-1:0]      seg,
  output logic [NUM_DIGITS-1:0] an,
  output logic                  ovf
);

  localparam int unsigned BCD_W   = NIB_W * NUM_DIGITS;
  localparam int unsigned PRESC_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0]   IDX_MAX   = IDX_W'(NUM_DIGITS - 1);

  logic [BCD_W-1:0]      w_digits;
  logic                  w_ovf;
  logic [PRESC_W-1:0]    r_presc;
  logic [IDX_W-1:0]      r_idx;
  logic                  w_wrap;
  logic [NUM_DIGITS-1:0] w_upper_zero;
  logic [NIB_W-1:0]      w_cur_nib;
  logic                  w_cur_blank;
  logic [SEG_W-1:0]      w_seg_nxt;
  logic [NUM_DIGITS-1:0] w_an_nxt;
  logic [SEG_W-1:0]      r_seg;
  logic [NUM_DIGITS-1:0] r_an;

  bcd_seq_converter #(
    .DATA_W     (DATA_W),
    .NUM_DIGITS (NUM_DIGITS)
  ) u_conv (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .digits   (w_digits),
    .ovf      (w_ovf)
  );

  assign w_wrap = (r_presc == PRESC_MAX);

  // Free-running scan, independent of conversions
  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc <= '0;
      r_idx   <= '0;
    end else begin
      r_presc <= w_wrap ? '0 : r_presc + PRESC_W'(1);
      if (w_wrap) begin
        r_idx <= (r_idx == IDX_MAX) ? '0 : r_idx + IDX_W'(1);
      end
    end
  end

  // w_upper_zero[i]: digits i..NUM_DIGITS-1 are all zero
  always_comb begin
    w_upper_zero = '0;
    w_upper_zero[NUM_DIGITS-1] = (w_digits[(NUM_DIGITS-1)*NIB_W +: NIB_W] == 4'd0);
    for (int i = int'(NUM_DIGITS) - 2; i >= 0; i--) begin
      w_upper_zero[i] = w_upper_zero[i+1] && (w_digits[i*NIB_W +: NIB_W] == 4'd0);
    end
  end

  always_comb begin
    w_cur_nib   = '0;
    w_cur_blank = 1'b0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (IDX_W'(i) == r_idx) begin
        w_cur_nib   = w_digits[i*NIB_W +: NIB_W];
        w_cur_blank = (BLANK_LZ != 0) && (i != 0) && !w_ovf && w_upper_zero[i];
      end
    end
    if (w_ovf) begin
      w_seg_nxt = SEG_DASH;
    end else if (w_cur_blank) begin
      w_seg_nxt = SEG_BLANK;
    end else begin
      w_seg_nxt = bcd_to_seg(w_cur_nib);
    end
    w_an_nxt = ~(NUM_DIGITS'(1) << r_idx);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_seg <= SEG_BLANK;
      r_an  <= '1;
    end else begin
      r_seg <= w_seg_nxt;
      r_an  <= w_an_nxt;
    end
  end

  assign seg = r_seg;
  assign an  = r_an;
  assign ovf = w_ovf;

endmodule

// File: tb/tb_seven_segment_mux.sv
// Scoreboard bench for seven_segment_mux: driver queues accepted values, a
// monitor checks scan order, segment contents, busy time and overflow.
module tb_seven_segment_mux;

  localparam int ND    = 4;
  localparam int DW    = 14;
  localparam int RD    = 4;
  localparam int LIMIT = 10000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready, ovf, in_ready_b, ovf_b;
  logic [6:0]    seg, seg_b;
  logic [ND-1:0] an, an_b;

  int checks = 0;
  int failures = 0;
  int q_exp[$];
  int hs_cnt;

  seven_segment_mux #(.NUM_DIGITS(ND), .DATA_W(DW), .REFRESH_DIV(RD), .BLANK_LZ(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .seg(seg), .an(an), .ovf(ovf)
  );

  seven_segment_mux #(.NUM_DIGITS(ND), .DATA_W(DW), .REFRESH_DIV(RD), .BLANK_LZ(0)) dut_nolz (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_data(in_data), .seg(seg_b), .an(an_b), .ovf(ovf_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] digit_code(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      default: return 7'b0010000;
    endcase
  endfunction

  // Expected segments of decimal position pos when val is displayed
  function automatic logic [6:0] exp_seg(input int val, input int pos, input bit blz);
    int p;
    p = 1;
    for (int i = 0; i < pos; i++) p = p * 10;
    if (val >= LIMIT) return 7'b0111111;
    if (blz && pos != 0 && val < p) return 7'b1111111;
    return digit_code((val / p) % 10);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send(input int v);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = DW'(v);
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    check("ready_wait", in_ready, 1);
    if (in_ready) q_exp.push_back(v);
    tick();
    in_valid = 1'b0;
  endtask

  // Monitor: k counts cycles since the last reset edge
  initial begin : monitor
    int  k, low_cnt, disp_val, v, idx;
    bit  armed, prev_rdy;
    k = 0; low_cnt = 0; disp_val = 0; armed = 0; prev_rdy = 1;
    forever begin
      @(negedge clk);
      if (armed) begin
        if (k == 0) begin
          check("rst_seg", seg, 7'b1111111);
          check("rst_an", an, 4'b1111);
          check("rst_ready", in_ready, 1);
          check("rst_ready_nolz", in_ready_b, 1);
          check("rst_ovf", ovf, 0);
        end else begin
          idx = ((k - 1) / RD) % ND;
          check("scan_an", an, ~(1 << idx) & 15);
          check("scan_an_nolz", an_b, ~(1 << idx) & 15);
          check("seg", seg, exp_seg(disp_val, idx, 1));
          check("seg_nolz", seg_b, exp_seg(disp_val, idx, 0));
          if (in_ready && !prev_rdy) begin
            check("busy_cycles", low_cnt, DW + 1);
            check("commit_expected", q_exp.size() > 0, 1);
            if (q_exp.size() > 0) begin
              v = q_exp.pop_front();
              check("ovf_commit", ovf, v >= LIMIT);
              check("ovf_commit_nolz", ovf_b, v >= LIMIT);
              disp_val = v;
            end
            low_cnt = 0;
          end else begin
            check("ovf", ovf, disp_val >= LIMIT);
          end
        end
        if (!in_ready) low_cnt++;
      end
      if (rst) begin
        armed = 1; k = 0; disp_val = 0; low_cnt = 0; prev_rdy = 1;
        q_exp.delete();
      end else begin
        k++;
        prev_rdy = in_ready;
      end
    end
  end

  initial begin : driver
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(40);
    send(1234);  idle(40);
    send(7);     idle(40);
    send(10000); idle(40);
    send(9999);  idle(40);

    // in_valid held while a conversion is in flight; data changes mid-window
    send(3);
    hs_cnt = 0;
    in_valid = 1'b1;
    for (int c = 0; c < 40; c++) begin
      in_data = (c < 20) ? DW'(5) : DW'(6);
      if (in_ready && !rst) begin
        q_exp.push_back(int'(in_data));
        hs_cnt++;
      end
      tick();
    end
    in_valid = 1'b0;
    check("held_valid_handshakes", hs_cnt, 2);
    idle(60);

    // Reset in cycle 8 of a conversion discards it
    send(4321);
    idle(7);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle(40);

    for (int r = 0; r < 12; r++) begin
      send(int'($urandom_range(0, 16383)));
      idle(int'($urandom_range(0, 40)));
    end
    idle(40);
    check("queue_drained", q_exp.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seven_segment_mux.md
# seven_segment_mux

Parametrised multi-digit seven-segment driver. It accepts a binary value over a valid/ready handshake and converts it to BCD with a sequential double-dabble engine. It then drives NUM_DIGITS common-anode digits by time-multiplexing one shared active-low segment bus. It adds leading-zero blanking and overflow indication, and replaces the single-digit switch decoder in board-level display paths.

## Interface
Parameters:
- NUM_DIGITS, 4, number of digits scanned; legal range 1..8.
- DATA_W, 14, width of the binary input; legal range 1..27.
- REFRESH_DIV, 50000, clk cycles each digit stays lit; must be at least 1.
- BLANK_LZ, 1, when 1 leading zeros are blanked; digit 0 is never blanked.

Ports:
- clk, input, 1, single clock; all state is updated on its rising edge.
- rst, input, 1, reset, synchronous and active-high.
- in_valid, input, 1, in_data is valid.
- in_ready, output, 1, block can accept a value; high exactly when the FSM is in IDLE.
- in_data, input, DATA_W, unsigned binary value to display.
- seg, output, 7, segment bus, active-low, bit order g f e d c b a (bit 6 = g).
- an, output, NUM_DIGITS, digit enables, active-low, one-hot-zero; an[0] is the rightmost, least significant digit.
- ovf, output, 1, the displayed value is at least 10^NUM_DIGITS.

## Operation
- Segment codes (gfedcba, active-low):
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000
  - DASH = 0111111, BLANK = 1111111
- Converter FSM states:
  - IDLE: in_ready = 1. On in_valid && in_ready, capture in_data into the shift register and clear the BCD register (4·NUM_DIGITS bits). Set pend_ovf = (in_data > 10^NUM_DIGITS − 1), load bit counter = DATA_W, go to SHIFT.
  - SHIFT: for each nibble ≥ 5, add 3. Then shift {bcd, bin} left by 1 and decrement the counter. When the counter reaches 1 on this step, go to COMMIT.
  - COMMIT: copy the BCD nibbles into the display digit registers and pend_ovf into ovf, then go to IDLE.
- in_valid while in_ready = 0 is ignored; nothing is queued. The source must hold in_valid until the handshake occurs.
- Values that overflow still run the full conversion. The resulting nibbles are don't-care, because the display shows DASH on every digit while ovf = 1.
- Scanning:
  - The prescaler counts 0..REFRESH_DIV−1 and wraps.
  - On each wrap, the digit index idx advances to (idx + 1) mod NUM_DIGITS.
  - an = ~(1 << idx).
- Digit i is blanked when BLANK_LZ = 1, i ≠ 0, ovf = 0, and digits i..NUM_DIGITS−1 are all zero.

## Timing
- Handshake accepted at the edge ending cycle t:
  - in_ready is low for cycles t+1 through t+DATA_W+1.
  - The digit registers and ovf update at the edge ending cycle t+DATA_W+1.
  - in_ready is high again in cycle t+DATA_W+2.
- seg and an are registered from idx and the digit registers, so they lag idx by one cycle. A commit appears on the current digit one cycle later.
- The scan runs continuously and independently of the converter. A commit mid-scan changes the digit contents without restarting the scan.
- Reset (any cycle, including mid-conversion): state goes to IDLE, the conversion in flight is discarded. The following are all cleared to 0: prescaler, idx, digit registers, ovf, pend_ovf.
- Output values while rst is high and in the first cycle after it: seg = BLANK, an = all ones, in_ready = 1. A handshake is never taken while rst is high.
- After reset, the display shows "0" on digit 0, with the other digits blanked when BLANK_LZ = 1 and showing "0" when BLANK_LZ = 0.
- When NUM_DIGITS = 1, idx stays at 0 and an = 0 (digit lit) after reset.
- When REFRESH_DIV = 1, idx advances every cycle.

## Structure
- Shared package seven_seg_pkg holds:
  - the SEG_0..SEG_9, SEG_DASH and SEG_BLANK constants;
  - a function bcd_to_seg(nibble) returning SEG_BLANK for nibbles above 9;
  - the converter FSM state enum.
- Sub-module bcd_seq_converter contains the IDLE/SHIFT/COMMIT FSM and pend_ovf logic, with parameters DATA_W and NUM_DIGITS.
- The top level contains the prescaler, scan index, blanking logic and output registers.

## Test plan
Bench configuration: NUM_DIGITS = 4, DATA_W = 14, REFRESH_DIV = 4, BLANK_LZ = 1 unless stated otherwise.
- Send 1234 after reset -> in_ready low for 15 cycles, then the scan shows seg = 0011001, 0110000, 0100100, 1111001 on an = 1110, 1101, 1011, 0111.
- Send 7 -> an = 1110 shows 1111000, the other three digits are BLANK; with BLANK_LZ = 0 they show 1000000.
- Send 10000 -> ovf = 1 and all four digits show 0111111; then send 9999 -> ovf = 0 and all digits show 0010000.
- Hold in_valid for 40 cycles with data changing from 5 to 6 -> accepted values are sampled only in cycles where in_ready = 1, and exactly 2 handshakes occur.
- Assert rst in cycle 8 of a conversion of 4321 -> in_ready = 1 next cycle, the digit registers stay at 0, and 4321 is never displayed.
- Free-run check -> an sequence 1110, 1101, 1011, 0111, 1110, each held for exactly 4 cycles, and it stays aligned across a commit.
